// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word and RAM status types for the CPU memory path
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/rr_select.sv
// rr_select: 2-core round-robin winner (in: per-core dren/dwen/iren, rr favored core; out: valid, core, data, wr)
module rr_select (
  input  logic [1:0] dren_i,
  input  logic [1:0] dwen_i,
  input  logic [1:0] iren_i,
  input  logic       rr_i,
  output logic       valid_o,
  output logic       core_o,
  output logic       data_o,
  output logic       wr_o
);
  logic [1:0] dreq;
  logic [1:0] req;
  assign dreq    = dren_i | dwen_i;
  assign req     = dreq | iren_i;
  assign valid_o = |req;
  assign core_o  = !(req[0] && (!rr_i || !req[1]));
  assign data_o  = dreq[core_o];
  assign wr_o    = dwen_i[core_o];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between two cores (in: per-core i/d requests+addresses, ramload, ramstate; out: waits, loads, RAM controls, timeout pulse)
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic      [CPUS-1:0] iREN,
  input  logic      [CPUS-1:0] dREN,
  input  logic      [CPUS-1:0] dWEN,
  input  word_t     [CPUS-1:0] iaddr,
  input  word_t     [CPUS-1:0] daddr,
  input  word_t     [CPUS-1:0] dstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic      [CPUS-1:0] iwait,
  output logic      [CPUS-1:0] dwait,
  output word_t     [CPUS-1:0] iload,
  output word_t     [CPUS-1:0] dload,
  output word_t                ramaddr,
  output word_t                ramstore,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic                 timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t     state_q, state_d;
  logic       rr_q, rr_d, core_q, core_d, d_q, d_d, wr_q, wr_d, to_q, to_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_valid, sel_core, sel_data, sel_wr, en, expire;
  rr_select u_sel (
    .dren_i (dREN[1:0]),
    .dwen_i (dWEN[1:0]),
    .iren_i (iREN[1:0]),
    .rr_i   (rr_q),
    .valid_o(sel_valid),
    .core_o (sel_core),
    .data_o (sel_data),
    .wr_o   (sel_wr)
  );
  assign iload   = {CPUS{ramload}};
  assign dload   = {CPUS{ramload}};
  assign timeout = to_q;
  // grantee still asking for the transfer type that was latched at arbitration
  assign en      = wr_q ? dWEN[core_q] : d_q ? dREN[core_q] : iREN[core_q];
  assign expire  = cnt_q == LAST;
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    core_d   = core_q;
    d_d      = d_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    to_d     = 1'b0;
    iwait    = '1;
    dwait    = '1;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    if (state_q == IDLE) begin
      if (sel_valid) begin
        state_d = GRANT;
        core_d  = sel_core;
        d_d     = sel_data;
        wr_d    = sel_wr;
        cnt_d   = '0;
      end
    end else begin
      ramaddr  = d_q ? daddr[core_q] : iaddr[core_q];
      ramstore = dstore[core_q];
      ramWEN   = wr_q;
      ramREN   = !wr_q;
      if (!en) begin
        state_d = IDLE;
      end else if (ramstate == ACCESS) begin
        state_d = IDLE;
        rr_d    = !core_q;
        if (d_q) dwait[core_q] = 1'b0;
        else iwait[core_q] = 1'b0;
      end else if (expire) begin
        state_d = IDLE;
        rr_d    = !core_q;
        to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      core_q  <= 1'b0;
      d_q     <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      core_q  <= core_d;
      d_q     <= d_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
  import cpu_types_pkg::*;
  localparam word_t A0 = 32'hA000_00A0, B1 = 32'hB100_00B1, C0 = 32'hC000_00C0;
  localparam word_t C1 = 32'hC100_00C1, D1 = 32'hD100_00D1, E1 = 32'hE100_00E1;
  logic            CLK = 1'b0;
  logic            RST;
  logic      [1:0] iREN, dREN, dWEN, iwait, dwait;
  word_t     [1:0] iaddr, daddr, dstore, iload, dload;
  word_t           ramload, ramaddr, ramstore;
  ramstate_t       ramstate;
  logic            ramREN, ramWEN, timeout, leak;
  int              total = 0;
  int              bad = 0;
  always #5 CLK = ~CLK;
  ram_arbiter dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ramload(ramload),
    .ramstate(ramstate), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
    .ramWEN(ramWEN), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    cyc; cyc;
    chk("rst_ren", ramREN, 0); chk("rst_wen", ramWEN, 0);
    chk("rst_iwait", iwait, 2'b11); chk("rst_dwait", dwait, 2'b11);
    chk("rst_to", timeout, 0); chk("rst_addr", ramaddr, 0); chk("rst_store", ramstore, 0);
    RST = 1'b0;
    // data read on core 0 with not-ready states before ACCESS
    dREN = 2'b01; daddr[0] = A0; daddr[1] = B1; dstore[0] = 32'h1234_5678;
    iaddr[0] = C0; iaddr[1] = C1; dstore[1] = E1; ramstate = BUSY; #1;
    chk("t1_idle_ren", ramREN, 0); chk("t1_idle_dwait", dwait, 2'b11);
    cyc;
    chk("t1_ren", ramREN, 1); chk("t1_wen", ramWEN, 0); chk("t1_addr", ramaddr, A0);
    chk("t1_busy_dwait", dwait, 2'b11);
    cyc;
    ramstate = ERROR; #1; chk("t1_err_dwait", dwait, 2'b11);
    ramstate = FREE; #1; chk("t1_free_dwait", dwait, 2'b11);
    ramstate = ACCESS; ramload = 32'h5555_AAAA; #1;
    chk("t1_acc_dwait", dwait, 2'b10); chk("t1_acc_iwait", iwait, 2'b11);
    chk("t1_dload0", dload[0], 32'h5555_AAAA); chk("t1_iload1", iload[1], 32'h5555_AAAA);
    cyc;
    chk("t1_after_dwait", dwait, 2'b11);
    dREN = 2'b11; ramstate = BUSY; #1;
    chk("t1_idle2_ren", ramREN, 0);
    cyc;
    chk("t1_rr1_addr", ramaddr, B1);
    ramstate = ACCESS; #1;
    chk("t1_rr1_dwait", dwait, 2'b01);
    cyc;
    // both cores fetch: grants alternate starting with core 0
    dREN = 2'b00; iREN = 2'b11; #1;
    for (int k = 0; k < 3; k++) begin
      cyc;
      chk("t2_addr", ramaddr, (k % 2) ? C1 : C0);
      chk("t2_iwait", iwait, (k % 2) ? 2'b01 : 2'b10);
      chk("t2_dwait", dwait, 2'b11);
      cyc;
      chk("t2_idle_iwait", iwait, 2'b11); chk("t2_idle_ren", ramREN, 0);
    end
    iREN = 2'b00;
    // core 1 write beats its own instruction fetch
    dWEN = 2'b10; iREN = 2'b10; daddr[1] = D1; #1;
    cyc;
    chk("t3_wen", ramWEN, 1); chk("t3_ren", ramREN, 0); chk("t3_addr", ramaddr, D1);
    chk("t3_store", ramstore, E1); chk("t3_dwait", dwait, 2'b01); chk("t3_iwait", iwait, 2'b11);
    cyc;
    dWEN = 2'b00; #1;
    chk("t3_idle_iwait", iwait, 2'b11);
    cyc;
    chk("t3_i_ren", ramREN, 1); chk("t3_i_wen", ramWEN, 0);
    chk("t3_i_addr", ramaddr, C1); chk("t3_i_iwait", iwait, 2'b01);
    cyc;
    // request dropped mid-grant aborts without completing and keeps rr at core 0
    iREN = 2'b00; dREN = 2'b01; ramstate = BUSY; #1;
    cyc;
    chk("t5_addr", ramaddr, A0); chk("t5_ren", ramREN, 1);
    cyc;
    dREN = 2'b00; ramstate = ACCESS; #1;
    chk("t5_drop_dwait", dwait, 2'b11);
    cyc;
    chk("t5_idle_ren", ramREN, 0); chk("t5_idle_to", timeout, 0);
    dREN = 2'b11; #1;
    cyc;
    chk("t5_rr_addr", ramaddr, A0); chk("t5_rr_dwait", dwait, 2'b10);
    cyc;
    // watchdog: 255 BUSY grant cycles then abort with a single timeout pulse
    dREN = 2'b01; ramstate = BUSY; #1;
    leak = 1'b0;
    cyc;
    for (int n = 1; n <= 255; n++) begin
      leak = leak | (dwait != 2'b11) | (iwait != 2'b11) | timeout | !ramREN;
      cyc;
    end
    chk("t4_no_early", leak, 0);
    chk("t4_to", timeout, 1); chk("t4_idle_ren", ramREN, 0); chk("t4_dwait", dwait, 2'b11);
    dREN = 2'b00;
    cyc;
    chk("t4_to_pulse", timeout, 0); chk("t4_idle2_ren", ramREN, 0);
    // async reset in the middle of a grant
    dREN = 2'b01; ramstate = BUSY; #1;
    cyc;
    chk("t6_ren", ramREN, 1);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_ren", ramREN, 0); chk("t6_rst_wen", ramWEN, 0);
    chk("t6_rst_dwait", dwait, 2'b11); chk("t6_rst_iwait", iwait, 2'b11);
    dREN = 2'b00;
    cyc;
    RST = 1'b0;
    cyc;
    chk("t6_post_ren", ramREN, 0); chk("t6_post_to", timeout, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
